// File: rtl/btn_pkg.sv
// ============================================================================
// Module : btn_pkg
// Brief  : Shared defaults and sizing helper for the button front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

  localparam int c_default_debounce_cycles = 50000;
  localparam int c_default_repeat_delay    = 25000000;
  localparam int c_default_repeat_period   = 5000000;

  // Bits needed to hold any value in 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module : debounce_channel
// Brief  : 2-FF synchroniser, debounce counter and optional auto-repeat for
//          one active-low button (auto-repeat built when BUTTON_REPEAT_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
`ifdef BUTTON_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = c_default_repeat_delay,
  parameter int REPEAT_PERIOD   = c_default_repeat_period
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic level,
  output logic press
);

  localparam int c_cnt_w = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_level;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_mismatch;
  logic               w_flip;
  logic               w_rise;
  logic               w_repeat;

  assign w_mismatch = r_sync ^ r_level;
  assign w_flip     = w_mismatch && (r_cnt == c_cnt_last);
  assign w_rise     = w_flip && !r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= ~button_n;
      r_sync  <= r_meta;
      r_press <= w_rise || w_repeat;
      // Any return to agreement restarts the count, so glitches never accumulate.
      if (w_flip) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int c_hold_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_hold_w   = cnt_width(c_hold_max);
  localparam logic [c_hold_w-1:0] c_delay_last  = c_hold_w'(REPEAT_DELAY - 1);
  localparam logic [c_hold_w-1:0] c_period_last = c_hold_w'(REPEAT_PERIOD - 1);

  logic [c_hold_w-1:0] r_hold;
  logic                r_repeating;

  // First target is the initial delay, every later one the repeat period.
  assign w_repeat = r_level && !w_flip &&
                    (r_hold == (r_repeating ? c_period_last : c_delay_last));

  always_ff @(posedge clk) begin
    if (reset || !r_level || w_flip) begin
      r_hold      <= '0;
      r_repeating <= 1'b0;
    end else if (w_repeat) begin
      r_hold      <= '0;
      r_repeating <= 1'b1;
    end else begin
      r_hold <= r_hold + 1'b1;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  assign level = r_level;
  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/button_event_capture.sv
// ============================================================================
// Module : button_event_capture
// Brief  : Debounced push-button front end with sticky press events and
//          overrun flags; BUTTON_REPEAT_EN adds hold-to-repeat presses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_event_capture
  import btn_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
  parameter int REPEAT_DELAY    = c_default_repeat_delay,
  parameter int REPEAT_PERIOD   = c_default_repeat_period
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_n,
  input  logic [N_BUTTONS-1:0] ack,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] events,
  output logic [N_BUTTONS-1:0] overrun,
  output logic                 event_pending
);

  logic [N_BUTTONS-1:0] w_press;
  logic [N_BUTTONS-1:0] w_events_next;
  logic [N_BUTTONS-1:0] w_overrun_next;
  logic [N_BUTTONS-1:0] r_events;
  logic [N_BUTTONS-1:0] r_overrun;
  logic                 r_pending;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .button_n (buttons_n[g]),
      .level    (level[g]),
      .press    (w_press[g])
    );
  end

  // A press in the ack cycle wins for events but is not counted as lost.
  assign w_events_next  = (r_events & ~ack) | w_press;
  assign w_overrun_next = (r_overrun & ~ack) | (w_press & r_events & ~ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_events  <= '0;
      r_overrun <= '0;
      r_pending <= 1'b0;
    end else begin
      r_events  <= w_events_next;
      r_overrun <= w_overrun_next;
      r_pending <= |w_events_next;
    end
  end

  assign events        = r_events;
  assign overrun       = r_overrun;
  assign event_pending = r_pending;

endmodule

`default_nettype wire
